// File: rtl/sparc_control_unit_pkg.sv
// sparc_ctl_pkg: shared definitions for the SPARC control unit.
//   - FSM state codes and decoded instruction classes
//   - SPARC opcode field constants (op, op2, op3)
//   - ALU operation codes driven on OpXX when MOP=1
//   - DataPath mux select encodings
//   - ctl_t: bundle of every control output, built per state by the FSM
package sparc_ctl_pkg;

  typedef enum logic [4:0] {
    ST_RST, ST_F0, ST_F1, ST_DEC, ST_ALU,
    ST_L0, ST_L1, ST_L2, ST_S0, ST_S1, ST_S2,
    ST_SETHI, ST_BRT, ST_CALL0, ST_CALL1, ST_PCU,
    ST_HALT, ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LD, CLS_ST, CLS_SETHI, CLS_BICC, CLS_CALL
  } cls_t;

  // IR[31:30]
  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_CALL = 2'b01;
  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [1:0] OP_MEM  = 2'b11;

  // IR[24:19] for memory ops, IR[24:22] for format 2
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_ST    = 6'b000100;
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // ALU codes used when the control unit overrides the IR op (MOP=1)
  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_PASS_A = 6'b100000;
  localparam logic [5:0] ALU_PASS_B = 6'b100001;

  // ALU B operand
  localparam logic [1:0] MB_RF  = 2'd0;  // rs2
  localparam logic [1:0] MB_IMM = 2'd1;  // sign-extended simm13 / sethi imm
  localparam logic [1:0] MB_PC  = 2'd2;  // PC
  localparam logic [1:0] MB_MDR = 2'd3;  // MDR
  // PC input
  localparam logic [1:0] MP_ZERO = 2'd0;
  localparam logic [1:0] MP_NPC  = 2'd3;
  // nPC input
  localparam logic [1:0] MNP_DISP = 2'd2;  // PC + displacement
  localparam logic [1:0] MNP_INC  = 2'd3;  // nPC + 4
  // register file write address
  localparam logic [1:0] MSC_RD  = 2'd0;
  localparam logic [1:0] MSC_R15 = 2'd1;
  // register file read port A address
  localparam logic MSA_RS1 = 1'b0;
  localparam logic MSA_RD  = 1'b1;
  // MDR input
  localparam logic MM_MEM = 1'b0;
  localparam logic MM_ALU = 1'b1;
  // ALU op source
  localparam logic MOP_IR  = 1'b0;
  localparam logic MOP_OPX = 1'b1;

  typedef struct packed {
    logic       IR_Ld;
    logic       MAR_Ld;
    logic       MDR_Ld;
    logic       PC_Ld;
    logic       NPC_Ld;
    logic       nPC_Clr;
    logic       FR_Ld;
    logic       RF_Load_Enable;
    logic       MOV;
    logic       RW;
    logic [1:0] MA;
    logic [1:0] MB;
    logic [1:0] MNP;
    logic [1:0] MP;
    logic [1:0] MSc;
    logic       MC;
    logic       MM;
    logic       MOP;
    logic       MSa;
    logic       MF;
    logic [5:0] OpXX;
    logic       Halt;
    logic       Error;
  } ctl_t;

endpackage

// File: rtl/sparc_control_unit_if.sv
// sparc_ctl_if: control bus between the control unit and the DataPath.
//   master : control unit (drives strobes/selects, reads IR, MOC, BCOND)
//   slave  : DataPath side
// Type is the memory access size (the SV keyword 'type' cannot be a name).
interface sparc_ctl_if;
  logic [31:0] IR;
  logic        MOC;
  logic        BCOND;
  logic        IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, RF_Load_Enable;
  logic        MOV, RW;
  logic [1:0]  Type;
  logic [1:0]  MA, MB, MNP, MP, MSc;
  logic        MC, MM, MOP, MSa, MF;
  logic [5:0]  OpXX;
  logic        Halt, Error;

  modport master (
    input  IR, MOC, BCOND,
    output IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, RF_Load_Enable,
           MOV, RW, Type, MA, MB, MNP, MP, MSc, MC, MM, MOP, MSa, MF, OpXX,
           Halt, Error
  );

  modport slave (
    output IR, MOC, BCOND,
    input  IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, RF_Load_Enable,
           MOV, RW, Type, MA, MB, MNP, MP, MSc, MC, MM, MOP, MSa, MF, OpXX,
           Halt, Error
  );
endinterface

// File: rtl/sparc_control_unit_decoder.sv
// sparc_ctl_decoder: combinational instruction classifier.
//   op      in  2  IR[31:30]
//   op3     in  6  IR[24:19] (IR[24:22] doubles as op2 for format 2)
//   cls     out    instruction class
//   illegal out 1  encoding outside the supported subset
// The DataPath ALU implements op3 0x00-0x1F (plain and cc forms); anything
// with op3[5] set under op=10 is treated as illegal.
module sparc_ctl_decoder
  import sparc_ctl_pkg::*;
(
  input  logic [1:0] op,
  input  logic [5:0] op3,
  output cls_t       cls,
  output logic       illegal
);

  logic [2:0] op2;
  assign op2 = op3[5:3];

  always_comb begin
    cls     = CLS_ALU;
    illegal = 1'b0;
    case (op)
      OP_ALU:  illegal = op3[5];
      OP_MEM: begin
        if (op3 == OP3_LD)      cls = CLS_LD;
        else if (op3 == OP3_ST) cls = CLS_ST;
        else                    illegal = 1'b1;
      end
      OP_FMT2: begin
        if (op2 == OP2_SETHI)     cls = CLS_SETHI;
        else if (op2 == OP2_BICC) cls = CLS_BICC;
        else                      illegal = 1'b1;
      end
      default: cls = CLS_CALL;
    endcase
  end

endmodule

// File: rtl/sparc_control_unit.sv
// sparc_control_unit: hardwired FSM sequencing the SPARC DataPath.
//   Clk   in  system clock, rising edge
//   Clr_n in  asynchronous active-low reset
//   bus   master side of sparc_ctl_if (IR/MOC/BCOND in, all strobes,
//         mux selects, OpXX, Halt, Error out)
// Outputs decode from state only, except IR_Ld/MDR_Ld which follow MOC
// inside the memory wait states. Memory waits give up after MOC_TIMEOUT
// cycles and park in ERROR.
module sparc_control_unit
  import sparc_ctl_pkg::*;
#(
  parameter int          MOC_TIMEOUT = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic         Clk,
  input  logic         Clr_n,
  sparc_ctl_if.master  bus
);

  // PC reset goes through MuxP input 0, which is hard zero in the DataPath.
  if (RESET_PC != 32'h0) begin : g_reset_pc_check
    $error("sparc_control_unit: only RESET_PC = 0 is supported");
  end

  localparam int CW = $clog2(MOC_TIMEOUT + 1);

  state_t         state, state_n;
  ctl_t           c;
  cls_t           cls;
  logic           illegal;
  logic [CW-1:0]  wait_cnt;
  logic           in_wait, timeout;
  logic           unused_ir;

  assign unused_ir = ^{bus.IR[29:25], bus.IR[18:14], bus.IR[12:0]};

  sparc_ctl_decoder u_dec (
    .op      (bus.IR[31:30]),
    .op3     (bus.IR[24:19]),
    .cls     (cls),
    .illegal (illegal)
  );

  assign in_wait = (state == ST_F1) || (state == ST_L1) || (state == ST_S2);
  // Last permitted wait cycle: count runs 0..MOC_TIMEOUT-1 while in a wait state.
  assign timeout = (wait_cnt == CW'(MOC_TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state    <= ST_RST;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (in_wait && state_n == state) wait_cnt <= wait_cnt + CW'(1);
      else                             wait_cnt <= '0;
    end
  end

  always_comb begin
    c       = '0;
    state_n = state;
    case (state)
      ST_RST: begin
        state_n = ST_F0;
        // Quiet while reset is held; act in the first cycle after release.
        if (Clr_n) begin
          c.PC_Ld   = 1'b1;
          c.MP      = MP_ZERO;
          c.nPC_Clr = 1'b1;
          c.NPC_Ld  = 1'b1;
          c.MNP     = MNP_INC;
        end
      end
      ST_F0: begin
        c.MAR_Ld = 1'b1;
        c.MB     = MB_PC;
        c.MOP    = MOP_OPX;
        c.OpXX   = ALU_PASS_B;
        state_n  = ST_F1;
      end
      ST_F1: begin
        c.MOV = 1'b1;
        c.RW  = 1'b1;
        if (bus.MOC) begin
          c.IR_Ld = 1'b1;
          state_n = ST_DEC;
        end else if (timeout) state_n = ST_ERROR;
      end
      ST_DEC: begin
        if (illegal) state_n = ST_HALT;
        else begin
          case (cls)
            CLS_ALU:   state_n = ST_ALU;
            CLS_LD:    state_n = ST_L0;
            CLS_ST:    state_n = ST_S0;
            CLS_SETHI: state_n = ST_SETHI;
            CLS_BICC:  state_n = bus.BCOND ? ST_BRT : ST_PCU;
            default:   state_n = ST_CALL0;
          endcase
        end
      end
      ST_ALU: begin
        c.MOP            = MOP_IR;
        c.MSa            = MSA_RS1;
        c.MSc            = MSC_RD;
        c.MB             = bus.IR[13] ? MB_IMM : MB_RF;
        c.RF_Load_Enable = 1'b1;
        c.FR_Ld          = bus.IR[23];  // op3[4]: cc-setting form
        state_n          = ST_PCU;
      end
      ST_L0, ST_S0: begin
        c.MAR_Ld = 1'b1;
        c.MB     = bus.IR[13] ? MB_IMM : MB_RF;
        c.MOP    = MOP_OPX;
        c.OpXX   = ALU_ADD;
        state_n  = (state == ST_L0) ? ST_L1 : ST_S1;
      end
      ST_L1: begin
        c.MOV = 1'b1;
        c.RW  = 1'b1;
        c.MM  = MM_MEM;
        if (bus.MOC) begin
          c.MDR_Ld = 1'b1;
          state_n  = ST_L2;
        end else if (timeout) state_n = ST_ERROR;
      end
      ST_L2: begin
        c.MB             = MB_MDR;
        c.MOP            = MOP_OPX;
        c.OpXX           = ALU_PASS_B;
        c.RF_Load_Enable = 1'b1;
        state_n          = ST_PCU;
      end
      ST_S1: begin
        c.MSa    = MSA_RD;
        c.MOP    = MOP_OPX;
        c.OpXX   = ALU_PASS_A;
        c.MM     = MM_ALU;
        c.MDR_Ld = 1'b1;
        state_n  = ST_S2;
      end
      ST_S2: begin
        c.MOV = 1'b1;
        c.RW  = 1'b0;
        if (bus.MOC)      state_n = ST_PCU;
        else if (timeout) state_n = ST_ERROR;
      end
      ST_SETHI: begin
        c.MB             = MB_IMM;
        c.MOP            = MOP_OPX;
        c.OpXX           = ALU_PASS_B;
        c.RF_Load_Enable = 1'b1;
        state_n          = ST_PCU;
      end
      ST_CALL0: begin
        c.MSc            = MSC_R15;
        c.MB             = MB_PC;
        c.MOP            = MOP_OPX;
        c.OpXX           = ALU_PASS_B;
        c.RF_Load_Enable = 1'b1;
        state_n          = ST_CALL1;
      end
      // Taken branch and CALL share the delayed-transfer step:
      // PC <= nPC, nPC <= PC + disp.
      ST_BRT, ST_CALL1: begin
        c.PC_Ld  = 1'b1;
        c.MP     = MP_NPC;
        c.NPC_Ld = 1'b1;
        c.MNP    = MNP_DISP;
        state_n  = ST_F0;
      end
      ST_PCU: begin
        c.PC_Ld  = 1'b1;
        c.MP     = MP_NPC;
        c.NPC_Ld = 1'b1;
        c.MNP    = MNP_INC;
        state_n  = ST_F0;
      end
      ST_HALT:  c.Halt  = 1'b1;
      ST_ERROR: c.Error = 1'b1;
      default:  state_n = ST_HALT;
    endcase
  end

  assign bus.IR_Ld          = c.IR_Ld;
  assign bus.MAR_Ld         = c.MAR_Ld;
  assign bus.MDR_Ld         = c.MDR_Ld;
  assign bus.PC_Ld          = c.PC_Ld;
  assign bus.NPC_Ld         = c.NPC_Ld;
  assign bus.nPC_Clr        = c.nPC_Clr;
  assign bus.FR_Ld          = c.FR_Ld;
  assign bus.RF_Load_Enable = c.RF_Load_Enable;
  assign bus.MOV            = c.MOV;
  assign bus.RW             = c.RW;
  assign bus.Type           = 2'b10;  // word accesses only
  assign bus.MA             = c.MA;
  assign bus.MB             = c.MB;
  assign bus.MNP            = c.MNP;
  assign bus.MP             = c.MP;
  assign bus.MSc            = c.MSc;
  assign bus.MC             = c.MC;
  assign bus.MM             = c.MM;
  assign bus.MOP            = c.MOP;
  assign bus.MSa            = c.MSa;
  assign bus.MF             = c.MF;
  assign bus.OpXX           = c.OpXX;
  assign bus.Halt           = c.Halt;
  assign bus.Error          = c.Error;

endmodule

// File: tb/tb_sparc_control_unit.sv
// Directed bench for sparc_control_unit. A tiny PC/nPC/IR model stands in
// for the DataPath so fetch addresses can be checked along with strobes.
module tb_sparc_control_unit;

  logic        Clk = 1'b0;
  logic        Clr_n = 1'b0;
  logic        moc = 1'b0;
  logic        bcond = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] mem_data = '0;
  logic [31:0] pc = '0, npc = '0;
  int          errors = 0;
  int          checks = 0;

  sparc_ctl_if bus ();
  assign bus.IR    = ir;
  assign bus.MOC   = moc;
  assign bus.BCOND = bcond;

  sparc_control_unit #(.MOC_TIMEOUT(16), .RESET_PC(32'h0)) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // strobe vector: IR_Ld MAR_Ld MDR_Ld PC_Ld NPC_Ld nPC_Clr FR_Ld RF MOV RW
  localparam logic [9:0] IRL = 10'h200, MARL = 10'h100, MDRL = 10'h080,
                         PCL = 10'h040, NPCL = 10'h020, NCLR = 10'h010,
                         FRL = 10'h008, RFL  = 10'h004, MOVB = 10'h002,
                         RWB = 10'h001;
  localparam logic [5:0] OPX_ADD = 6'h00, OPX_PA = 6'h20, OPX_PB = 6'h21;

  logic [9:0] stb;
  assign stb = {bus.IR_Ld, bus.MAR_Ld, bus.MDR_Ld, bus.PC_Ld, bus.NPC_Ld,
                bus.nPC_Clr, bus.FR_Ld, bus.RF_Load_Enable, bus.MOV, bus.RW};

  // DataPath stand-in: IR load, PC/nPC update.
  logic [31:0] disp;
  assign disp = (ir[31:30] == 2'b01) ? {ir[29:0], 2'b00}
                                     : {{8{ir[21]}}, ir[21:0], 2'b00};
  always @(posedge Clk) begin
    if (bus.IR_Ld) ir <= mem_data;
    if (bus.NPC_Ld) begin
      if (bus.MNP == 2'd3)      npc <= (bus.nPC_Clr ? 32'h0 : npc) + 32'd4;
      else if (bus.MNP == 2'd2) npc <= pc + disp;
    end else if (bus.nPC_Clr) npc <= 32'h0;
    if (bus.PC_Ld) begin
      if (bus.MP == 2'd0)      pc <= 32'h0;
      else if (bus.MP == 2'd3) pc <= npc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Entered positioned in F0; leaves positioned in DEC.
  task automatic fetch(input logic [31:0] word, input int dly, input logic [31:0] exp_pc);
    chk("f0_stb", stb, MARL);
    chk("f0_mb", bus.MB, 2);
    chk("f0_opxx", bus.OpXX, OPX_PB);
    chk("f0_pc", pc, exp_pc);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("f1_wait", stb, MOVB | RWB);
    end
    tick();
    mem_data = word;
    moc = 1'b1;
    #1;
    chk("f1_moc", stb, IRL | MOVB | RWB);
    tick();
    moc = 1'b0;
    #1;
    chk("dec_stb", stb, 0);
  endtask

  // Advances into PCU, checks it, then advances into F0.
  task automatic pcu();
    tick();
    moc = 1'b0;
    #1;
    chk("pcu_stb", stb, PCL | NPCL);
    chk("pcu_mp", bus.MP, 3);
    chk("pcu_mnp", bus.MNP, 3);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(posedge Clk);
    #2;
    chk("rst_stb", stb, 0);
    chk("rst_halt", bus.Halt, 0);
    chk("rst_error", bus.Error, 0);
    chk("rst_mb", bus.MB, 0);
    Clr_n = 1'b1;
    #1;
    chk("rst_exit_stb", stb, PCL | NPCL | NCLR);
    chk("rst_exit_mp", bus.MP, 0);
    chk("rst_exit_mnp", bus.MNP, 3);
    chk("type", bus.Type, 2);

    // ADD r1,r2,r3 at 0, MOC one cycle late
    tick();
    chk("npc_after_rst", npc, 4);
    fetch(32'h86004002, 1, 32'h0);
    tick();
    chk("add_stb", stb, RFL);
    chk("add_mb", bus.MB, 0);
    chk("add_mop", bus.MOP, 0);
    pcu();
    chk("add_npc", npc, 8);

    // ADDcc r1,5,r1 at 4
    fetch(32'h82806005, 0, 32'h4);
    tick();
    chk("addcc_stb", stb, RFL | FRL);
    chk("addcc_mb", bus.MB, 1);
    pcu();

    // BA +4 taken at 8
    bcond = 1'b1;
    fetch(32'h10800004, 0, 32'h8);
    tick();
    chk("ba_t_stb", stb, PCL | NPCL);
    chk("ba_t_mp", bus.MP, 3);
    chk("ba_t_mnp", bus.MNP, 2);
    tick();
    bcond = 1'b0;
    chk("ba_t_npc", npc, 24);

    // SETHI in the delay slot at 12
    fetch(32'h05112345, 0, 32'hC);
    tick();
    chk("sethi_stb", stb, RFL);
    chk("sethi_mb", bus.MB, 1);
    chk("sethi_opxx", bus.OpXX, OPX_PB);
    pcu();

    // BA at 24 not taken: DEC goes straight to PCU
    fetch(32'h10800004, 0, 32'd24);
    pcu();

    // LD [r0+0x20],r4 at 28, MOC after 3 wait cycles
    fetch(32'hC8002020, 0, 32'd28);
    tick();
    chk("ld_l0_stb", stb, MARL);
    chk("ld_l0_opxx", bus.OpXX, OPX_ADD);
    chk("ld_l0_mb", bus.MB, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_wait", stb, MOVB | RWB);
    end
    tick();
    moc = 1'b1;
    #1;
    chk("ld_moc", stb, MOVB | RWB | MDRL);
    chk("ld_mm", bus.MM, 0);
    tick();
    moc = 1'b0;
    #1;
    chk("ld_l2_stb", stb, RFL);
    chk("ld_l2_mb", bus.MB, 3);
    pcu();

    // ST r4,[r0+0x20] at 32
    fetch(32'hC8202020, 0, 32'd32);
    tick();
    chk("st_s0_stb", stb, MARL);
    tick();
    chk("st_s1_stb", stb, MDRL);
    chk("st_s1_msa", bus.MSa, 1);
    chk("st_s1_mm", bus.MM, 1);
    chk("st_s1_opxx", bus.OpXX, OPX_PA);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_wait", stb, MOVB);
    end
    tick();
    moc = 1'b1;
    #1;
    chk("st_moc", stb, MOVB);
    pcu();

    // CALL +0x40 at 36
    fetch(32'h40000010, 0, 32'd36);
    tick();
    chk("call0_stb", stb, RFL);
    chk("call0_msc", bus.MSc, 1);
    chk("call0_mb", bus.MB, 2);
    tick();
    chk("call1_stb", stb, PCL | NPCL);
    chk("call1_mnp", bus.MNP, 2);
    tick();
    chk("call_npc", npc, 32'd100);

    // illegal op3 0x3F at 40
    fetch(32'h81F80000, 0, 32'd40);
    tick();
    chk("halt_stb", stb, 0);
    chk("halt", bus.Halt, 1);
    moc = 1'b1;
    repeat (3) tick();
    chk("halt_moc_ignored", stb, 0);
    chk("halt_sticky", bus.Halt, 1);
    moc = 1'b0;

    // reset clears Halt, then reset mid-F1 drops MOV immediately
    Clr_n = 1'b0;
    #1;
    chk("halt_cleared", bus.Halt, 0);
    tick();
    Clr_n = 1'b1;
    tick();
    chk("restart_pc", pc, 0);
    chk("restart_stb", stb, MARL);
    tick();
    chk("f1_mov", stb, MOVB | RWB);
    Clr_n = 1'b0;
    #1;
    chk("mov_drop", stb, 0);
    tick();
    Clr_n = 1'b1;

    // MOC never arrives: 16 wait cycles then ERROR
    tick();
    chk("to_f0_pc", pc, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("to_wait", stb, MOVB | RWB);
    end
    tick();
    chk("to_error", bus.Error, 1);
    chk("to_stb", stb, 0);
    repeat (2) tick();
    chk("error_sticky", bus.Error, 1);
    Clr_n = 1'b0;
    #1;
    chk("error_cleared", bus.Error, 0);
    tick();
    Clr_n = 1'b1;
    tick();
    chk("post_err_pc", pc, 0);
    chk("post_err_stb", stb, MARL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sparc_control_unit.md
Name: sparc_control_unit

Overview:
Hardwired FSM control unit that sequences the SPARC DataPath through fetch, decode, execute and PC-update for a reduced instruction subset: Format-3 ALU ops, LD/ST word, SETHI, Bicc and CALL. It drives every DataPath control input and uses the datapath's returned IR, MOC and BCOND. It sits beside DataPath at CPU top level, so a complete processor is the DataPath and this block.

Parameters:
MOC_TIMEOUT, 16, max cycles waiting for MOC before entering ERROR
RESET_PC, 0, value forced into PC on reset exit (via MuxP input 0; only 0 supported)

Ports:
Clk  in  1  system clock, rising edge
Clr_n  in  1  asynchronous active-low reset
IR  in  32  instruction register contents (wIROut)
MOC  in  1  memory operation complete
BCOND  in  1  branch condition true for IR
IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, RF_Load_Enable  out  1 each  register load/clear strobes
MOV, RW  out  1 each  memory valid; RW=1 read, RW=0 write
type  out  2  memory access size (always word, 2'b10)
MA, MB, MNP, MP, MSc  out  2 each  mux selects
MC, MM, MOP, MSa, MF  out  1 each  mux selects
OpXX  out  6  ALU op when MOP=1
Halt  out  1  illegal instruction encountered, sticky until reset
Error  out  1  MOC timeout, sticky until reset

Behaviour:
- Async reset (Clr_n=0): state=RST. All strobes 0, MOV=0, all selects 0, Halt=Error=0. MOV drops immediately, even mid-access.
- RST (1 cycle after release): PC_Ld=1 with MP=0 (PC<=0). nPC_Clr=1 then NPC_Ld=1 with MNP=3 gives nPC=4. Go to F0.
- F0: MAR<=PC through ALU pass-B (MB=2, MC=0, MOP=1, OpXX=ALU_PASS_B, MAR_Ld=1). Go to F1.
- F1: MOV=1, RW=1, type=2'b10. Hold until MOC=1, then IR_Ld=1 in the same cycle. Go to DEC.
  - Wait counter starts at 0 on entry. If MOC is still 0 when the count reaches MOC_TIMEOUT, go to ERROR.
- DEC: decode IR[31:30] and op3=IR[24:19]. Undefined op3 goes to HALT.
- ALU (op=10): ALU ops only; MOP=0, MSa=0, MSc=0, MA=0.
  - MB=1 if IR[13] else MB=0.
  - RF_Load_Enable=1; FR_Ld=1 only when op3[4]=1 (cc variants).
  - Go to PCU.
- LD (op=11, op3=000000):
  - L0: MAR<=rs1+op2 (ALU_ADD).
  - L1: MOV=1, RW=1, wait MOC. On MOC, MDR_Ld=1 with MM=0.
  - L2: rd<=MDR through pass-B (MB=3), RF_Load_Enable=1. Go to PCU.
- ST (op=11, op3=000100):
  - S0: MAR<=rs1+op2.
  - S1: MSa=1, pass-A of rd, MM=1, MDR_Ld=1.
  - S2: MOV=1, RW=0, wait MOC. Go to PCU.
  - Both LD and ST memory waits share the timeout rule.
- SETHI (op=00, op2=100): MB=1, pass-B, RF_Load_Enable. Go to PCU.
- Bicc (op=00, op2=010):
  - BCOND=1: PC_Ld with MP=3 (PC<=nPC); NPC_Ld with MNP=2 (nPC<=PC+disp). Go to F0.
  - BCOND=0: go to PCU.
  - Annul bit is ignored.
- CALL (op=01): r15<=PC (MSc=1, MB=2, MC=0, pass-B, RF_Load_Enable).
  - Next cycle: PC<=nPC (MP=3), nPC<=PC+disp30 (MNP=2). Go to F0.
- PCU: PC_Ld with MP=3 (PC<=nPC); NPC_Ld with MNP=3 (nPC<=nPC+4). Go to F0.
- HALT and ERROR are absorbing states; all strobes and MOV stay 0 until reset.
- Outputs are Moore, registered from state, except IR_Ld and MDR_Ld: these are Mealy on MOC inside wait states.
  - Latency: 3 cycles for fetch plus memory wait.
  - ALU instruction = 5 cycles with 1-cycle MOC.
- MOC asserted outside a wait state is ignored.
- PC wraps modulo 2^32 (datapath adders). No extra handling.

Decomposition:
- Package sparc_ctl_pkg holds:
  - state enum codes
  - opcode constants OP_FMT2, OP_CALL, OP_ALU, OP_MEM, OP3_LD, OP3_ST, OP2_BICC, OP2_SETHI
  - ALU op constants ALU_ADD=6'b000000 and ALU_PASS_A / ALU_PASS_B, equal to the alu module's pass codes
  - mux select encodings
- One sub-module, sparc_ctl_decoder: combinational IR to instruction class plus illegal flag. The FSM and timeout counter stay in the top.

Test Plan:
- Reset release, memory word 0 = ADD r1,r2,r3 (0x86004002), MOC 1 cycle after MOV -> MAR_Ld in cycle 2, IR_Ld with MOC, RF_Load_Enable once, PC=4 and nPC=8 after PCU; FR_Ld stays 0.
- ADDcc with immediate 5 (IR[13]=1) -> MB=1, FR_Ld=1 in the execute cycle.
- LD then ST to address 0x20 with MOC delayed 3 cycles -> MOV held 3 cycles; RW=1 for LD and 0 for ST; MDR_Ld exactly once per access.
- BA disp=+4 (BCOND=1) at PC=8 -> next fetch from nPC=12, then from 8+16=24. Repeat with BCOND=0 -> sequential fetch 12, 16.
- MOC never asserted in F1 -> Error=1 after 16 wait cycles; MOV=0 thereafter; Clr_n pulse clears Error and restarts at PC=0.
- Illegal op3 0x3F with op=10 -> Halt=1, no RF/FR/PC strobes. Clr_n asserted mid-F1 -> MOV falls the same cycle.
